inv_mix_col_seq: RTL and testbench
==================================

Name: inv_mix_col_seq

Overview:
- Column-serial sequencer for decryption-round InvMixColumns.
- Accepts a 128-bit state over a valid/ready handshake and time-multiplexes one shared 32-bit single-column InvMixColumns unit across the columns, one column per cycle.
- Reassembles the result and presents it downstream over valid/ready.
- Supports a per-block bypass for the final decryption round, which skips InvMixColumns.

Parameters:
- NUM_COLS, 4, number of 32-bit columns per state; state width = 32*NUM_COLS.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  block can accept a state
- in_state  input  32*NUM_COLS  state; column c = bits [32c +: 32], row r of column c = bits [32c+8r +: 8]
- in_bypass  input  1  sampled with in_state; 1 = pass state through unchanged
- col_en  output  1  shared column unit is being driven this cycle
- col_out  output  32  column presented to shared unit
- col_in  input  32  combinational InvMixColumns result of col_out, same cycle
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_state  output  32*NUM_COLS  result state
- busy  output  1  not IDLE
- blk_count  output  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Reset (clk edge with rst=1): state IDLE, in_ready=1, out_valid=0, col_en=0, col_out=0, out_state=0, busy=0, blk_count=0, col_idx=0.
- Reset mid-operation aborts: partial result discarded, nothing emitted.
- rst has priority over every other event.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_state into src register and into res register.
  - bypass=1 -> DONE; bypass=0 -> RUN with col_idx=0.
- RUN:
  - in_ready=0, col_en=1, col_out=src[32*col_idx +: 32].
  - Each edge writes col_in into res[32*col_idx +: 32] and increments col_idx.
  - On the edge writing col_idx=NUM_COLS-1: -> DONE, col_idx=0.
  - Inputs in_valid/in_state are ignored while in RUN.
- DONE:
  - out_valid=1, out_state=res, held stable while out_ready=0.
  - On out_valid&out_ready: -> IDLE, blk_count += 1 (wraps modulo 2^CNT_W).
- Outside RUN: col_en=0 and col_out=0.
- Latency, accept edge to first cycle out_valid=1:
  - NUM_COLS+1 edges in normal mode (5 at default).
  - 1 edge in bypass.
- Throughput at default with out_ready tied high: one block per 6 cycles; bypass blocks one per 2 cycles.
- No overlap: in_ready=0 in RUN and DONE, including the cycle the output handshake completes. Next accept is possible at the following edge.
- out_state retains the last result after leaving DONE until overwritten by the next completion.
- busy = (state != IDLE).
- Illegal FSM encodings recover to IDLE.

Test Plan:
- Single column vector, NUM_COLS=4, shared unit modelled in bench:
  - in_state = 128'hbca14d8e_bca14d8e_bca14d8e_bca14d8e, bypass=0.
  - Required: out_state = 128'h455313db repeated in all four columns.
  - Required: out_valid first high exactly 5 edges after the accept edge.
  - Required: col_en high for exactly 4 cycles, with col_out stepping columns 0,1,2,3.
- Mixed columns:
  - Columns 0..3 = 32'hbca14d8e, 32'hc6c6c6c6, 32'h01010101, 32'hd6d7d5d5.
  - Required out columns: 32'h455313db, 32'hc6c6c6c6, 32'h01010101, 32'hd5d4d4d4.
- Bypass:
  - in_bypass=1, in_state = 128'h00112233445566778899aabbccddeeff.
  - Required: out_state identical, out_valid 1 edge after accept, col_en never asserted.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE.
  - Required: out_valid stays 1, out_state stable, in_ready stays 0, blk_count unchanged.
  - Then out_ready=1 for one cycle. Required: blk_count increments by 1, in_ready=1 on the next cycle.
- Reset mid-RUN:
  - Assert rst while col_idx=2.
  - Required next cycle: IDLE, in_ready=1, out_valid=0, blk_count=0.
  - A fresh block then completes correctly.
- Counter wrap:
  - Preload via 65536 back-to-back bypass blocks, CNT_W=16.
  - Required: blk_count returns to 16'h0000 after the 65536th output handshake.

Source files
------------

// File: rtl/inv_mix_col_seq.sv
// Column-serial InvMixColumns sequencer: one shared 32-bit column unit is time-shared
// across the NUM_COLS columns of a state, with a per-block bypass for the final round.
module inv_mix_col_seq #(
  parameter int NUM_COLS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NUM_COLS-1:0] in_state,
  input  logic                  in_bypass,
  output logic                  col_en,
  output logic [31:0]           col_out,
  input  logic [31:0]           col_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_COLS-1:0] out_state,
  output logic                  busy,
  output logic [CNT_W-1:0]      blk_count
);
  localparam int SW    = 32*NUM_COLS;
  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_src;
  logic [SW-1:0]    r_res;
  logic [SW-1:0]    r_out_state;
  logic [IDX_W-1:0] r_col_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_col_en;
  logic [31:0]      r_col_out;
  logic             r_busy;
  logic [CNT_W-1:0] r_blk_count;

  logic [SW-1:0]    w_res_upd;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_last;

  // Result with the column currently in the shared unit merged in; on the last
  // column this is the complete output and goes straight to out_state.
  always_comb begin
    w_res_upd = r_res;
    w_res_upd[32*r_col_idx +: 32] = col_in;
    w_nxt_idx = r_col_idx + 1'b1;
    w_last    = (r_col_idx == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_res       <= '0;
      r_out_state <= '0;
      r_col_idx   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_col_en    <= 1'b0;
      r_col_out   <= '0;
      r_busy      <= 1'b0;
      r_blk_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_src      <= in_state;
            r_res      <= in_state;
            r_col_idx  <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (in_bypass) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_state <= in_state;
            end else begin
              r_state   <= S_RUN;
              r_col_en  <= 1'b1;
              r_col_out <= in_state[31:0];
            end
          end
        end
        S_RUN: begin
          r_res <= w_res_upd;
          if (w_last) begin
            r_state     <= S_DONE;
            r_col_idx   <= '0;
            r_col_en    <= 1'b0;
            r_col_out   <= '0;
            r_out_valid <= 1'b1;
            r_out_state <= w_res_upd;
          end else begin
            r_col_idx <= w_nxt_idx;
            r_col_out <= r_src[32*w_nxt_idx +: 32];
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_blk_count <= r_blk_count + 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_col_idx   <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_col_en    <= 1'b0;
          r_col_out   <= '0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign col_en    = r_col_en;
  assign col_out   = r_col_out;
  assign out_state = r_out_state;
  assign busy      = r_busy;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Self-checking bench for inv_mix_col_seq; the shared column unit and the block
// reference are modelled here with plain GF(2^8) arithmetic.
module tb_inv_mix_col_seq;
  localparam int NUM_COLS = 4;
  // Narrow counter keeps the full-wrap run short; wrap behaviour is width-generic.
  localparam int CNT_W    = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_state;
  logic               in_bypass;
  logic               col_en;
  logic [31:0]        col_out;
  logic [31:0]        col_in;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       out_state;
  logic               busy;
  logic [CNT_W-1:0]   blk_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          lat;
  int          en_cnt;
  logic [31:0] seen_cols[$];

  always #5 clk = ~clk;

  inv_mix_col_seq #(.NUM_COLS(NUM_COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_bypass(in_bypass), .col_en(col_en),
    .col_out(col_out), .col_in(col_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy),
    .blk_count(blk_count)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a[4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[8*i +: 8];
    r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = gmul(a[i], 8'h0e) ^ gmul(a[(i+1)%4], 8'h0b) ^
                    gmul(a[(i+2)%4], 8'h0d) ^ gmul(a[(i+3)%4], 8'h09);
    return r;
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] s, input logic byp);
    logic [127:0] r;
    if (byp) return s;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = inv_col(s[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // External shared column unit: combinational, same cycle.
  assign col_in = inv_col(col_out);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  // Present one state for the accept edge (caller ensures in_ready=1).
  task automatic accept(input logic [127:0] st, input logic byp);
    in_valid = 1'b1; in_state = st; in_bypass = byp;
    tick();
    in_valid = 1'b0; in_state = rnd128(); in_bypass = $urandom_range(0, 1);
  endtask

  // Counts edges from the accept edge (inclusive) to out_valid, logging columns.
  task automatic wait_out(input bit noise);
    lat = 1; en_cnt = 0; seen_cols.delete();
    while (!out_valid && lat < 40) begin
      if (col_en) begin en_cnt++; seen_cols.push_back(col_out); end
      if (noise) begin in_valid = $urandom_range(0, 1); in_state = rnd128(); end
      tick();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({in_ready, out_valid, col_en, busy} !== 4'b1000) $display("FAIL reset_ctl got %b want 1000", {in_ready, out_valid, col_en, busy});
    else pass_cnt++;
    total_cnt++;
    if (col_out !== 32'h0 || out_state !== 128'h0) $display("FAIL reset_data col_out=%h out_state=%h want 0", col_out, out_state);
    else pass_cnt++;
    total_cnt++;
    if (blk_count !== '0) $display("FAIL reset_cnt got %0d want 0", blk_count);
    else pass_cnt++;
  endtask

  task automatic test_single_col();
    logic [127:0] st;
    st = {4{32'hbca14d8e}};
    accept(st, 1'b0);
    wait_out(1'b0);
    total_cnt++;
    if (lat !== 5) $display("FAIL single_latency got %0d want 5", lat); else pass_cnt++;
    total_cnt++;
    if (en_cnt !== 4) $display("FAIL single_col_en got %0d want 4", en_cnt); else pass_cnt++;
    total_cnt++;
    if (seen_cols.size() != 4 || seen_cols[0] !== st[31:0] || seen_cols[3] !== st[127:96])
      $display("FAIL single_col_seq got %0d cols want 4 of %h", seen_cols.size(), st[31:0]);
    else pass_cnt++;
    total_cnt++;
    if (out_state !== {4{32'h455313db}}) $display("FAIL single_result got %h want %h", out_state, {4{32'h455313db}});
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_mixed();
    logic [127:0] st, exp;
    st  = {32'hd6d7d5d5, 32'h01010101, 32'hc6c6c6c6, 32'hbca14d8e};
    exp = {32'hd5d4d4d4, 32'h01010101, 32'hc6c6c6c6, 32'h455313db};
    accept(st, 1'b0);
    wait_out(1'b0);
    total_cnt++;
    if (seen_cols.size() != 4) $display("FAIL mixed_col_cnt got %0d want 4", seen_cols.size());
    else if (seen_cols[1] !== st[63:32] || seen_cols[2] !== st[95:64]) $display("FAIL mixed_col_seq got %h %h", seen_cols[1], seen_cols[2]);
    else pass_cnt++;
    total_cnt++;
    if (out_state !== exp) $display("FAIL mixed_result got %h want %h", out_state, exp); else pass_cnt++;
    handshake();
  endtask

  task automatic test_bypass();
    logic [127:0] st;
    st = 128'h00112233445566778899aabbccddeeff;
    accept(st, 1'b1);
    wait_out(1'b0);
    total_cnt++;
    if (lat !== 1) $display("FAIL bypass_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++;
    if (en_cnt !== 0) $display("FAIL bypass_col_en got %0d want 0", en_cnt); else pass_cnt++;
    total_cnt++;
    if (out_state !== st) $display("FAIL bypass_result got %h want %h", out_state, st); else pass_cnt++;
    handshake();
  endtask

  task automatic test_backpressure();
    logic [127:0] st, held;
    logic [CNT_W-1:0] cnt0;
    st = rnd128();
    accept(st, 1'b0);
    wait_out(1'b0);
    held = out_state; cnt0 = blk_count;
    total_cnt++;
    if (held !== ref_block(st, 1'b0)) $display("FAIL bp_result got %h want %h", held, ref_block(st, 1'b0)); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_state = rnd128();
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_state !== held || in_ready !== 1'b0 || blk_count !== cnt0)
        $display("FAIL bp_hold cyc %0d got v=%b r=%b cnt=%0d want v=1 r=0 cnt=%0d", i, out_valid, in_ready, blk_count, cnt0);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    handshake();
    total_cnt++;
    if (blk_count !== cnt0 + 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got cnt=%0d r=%b v=%b want cnt=%0d r=1 v=0", blk_count, in_ready, out_valid, cnt0 + 1'b1);
    else pass_cnt++;
    total_cnt++;
    if (out_state !== held) $display("FAIL bp_retain got %h want %h", out_state, held); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] st;
    accept(rnd128(), 1'b0);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total_cnt++;
    if ({in_ready, out_valid, busy, col_en} !== 4'b1000 || blk_count !== '0)
      $display("FAIL midrst_state got rdy/v/busy/en=%b cnt=%0d want 1000 cnt=0", {in_ready, out_valid, busy, col_en}, blk_count);
    else pass_cnt++;
    st = rnd128();
    accept(st, 1'b0);
    wait_out(1'b0);
    total_cnt++;
    if (lat !== 5 || out_state !== ref_block(st, 1'b0))
      $display("FAIL midrst_fresh got lat=%0d %h want lat=5 %h", lat, out_state, ref_block(st, 1'b0));
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_random();
    logic [127:0] st;
    logic byp;
    logic [CNT_W-1:0] cnt0;
    for (int n = 0; n < 30; n++) begin
      st = rnd128(); byp = ($urandom_range(0, 3) == 0);
      cnt0 = blk_count;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL rnd_ready blk %0d got %b want 1", n, in_ready); else pass_cnt++;
      accept(st, byp);
      wait_out(1'b1);
      total_cnt++;
      if (lat !== (byp ? 1 : 5) || en_cnt !== (byp ? 0 : 4))
        $display("FAIL rnd_timing blk %0d got lat=%0d en=%0d want lat=%0d", n, lat, en_cnt, byp ? 1 : 5);
      else pass_cnt++;
      for (int c = 0; c < seen_cols.size(); c++) begin
        total_cnt++;
        if (seen_cols[c] !== st[32*c +: 32]) $display("FAIL rnd_col blk %0d col %0d got %h want %h", n, c, seen_cols[c], st[32*c +: 32]);
        else pass_cnt++;
      end
      repeat ($urandom_range(0, 3)) tick();
      total_cnt++;
      if (out_state !== ref_block(st, byp) || in_ready !== 1'b0)
        $display("FAIL rnd_result blk %0d got %h want %h", n, out_state, ref_block(st, byp));
      else pass_cnt++;
      handshake();
      total_cnt++;
      if (blk_count !== cnt0 + 1'b1) $display("FAIL rnd_cnt blk %0d got %0d want %0d", n, blk_count, cnt0 + 1'b1);
      else pass_cnt++;
    end
  endtask

  task automatic test_counter_wrap();
    int nblk;
    nblk = 1 << CNT_W;
    do_reset();
    in_valid = 1'b1; in_bypass = 1'b1; in_state = rnd128(); out_ready = 1'b1;
    for (int i = 0; i < 2*nblk - 2; i++) tick();
    total_cnt++;
    if (blk_count !== {CNT_W{1'b1}}) $display("FAIL wrap_pre got %0d want %0d", blk_count, nblk - 1); else pass_cnt++;
    tick(); tick();
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (blk_count !== '0) $display("FAIL wrap_zero got %0d want 0", blk_count); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single_col();
    test_mixed();
    test_bypass();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
